// File: rtl/byte_exec_pipe.sv
// byte_exec_pipe: byte-wise SIMD execute unit (cntb / avgb / absdb / sumb)
// feeding a LATENCY-deep writeback pipeline with stall, flush and sync reset.

package byte_exec_pkg;
   typedef enum logic [1:0] {
      SEL_CNTB  = 2'd0,
      SEL_AVGB  = 2'd1,
      SEL_ABSDB = 2'd2,
      SEL_SUMB  = 2'd3
   } sel_e;
endpackage

// One 32-bit word of the datapath. Byte 3 of the packed view is the most
// significant byte, i.e. big-endian byte 0 of the word.
module byte_exec_lane
   import byte_exec_pkg::*;
(
   input  sel_e        sel_i,
   input  logic [31:0] ra_i,
   input  logic [31:0] rb_i,
   output logic [31:0] res_o
);

   logic [3:0][7:0] a, b;
   logic [3:0][7:0] cnt, avg, absd;
   logic [9:0]      sum_a, sum_b;

   assign a = ra_i;
   assign b = rb_i;

   function automatic logic [7:0] popcnt8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int j = 0; j < 8; j++) c = c + {3'd0, v[j]};
      return {4'd0, c};
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g_byte
      // 9-bit intermediate keeps the carry of a+b+1 before halving
      logic [8:0] s9;
      assign s9      = {1'b0, a[k]} + {1'b0, b[k]} + 9'd1;
      assign avg[k]  = s9[8:1];
      assign cnt[k]  = popcnt8(a[k]);
      assign absd[k] = (b[k] >= a[k]) ? (b[k] - a[k]) : (a[k] - b[k]);
   end

   // max 4*255 = 1020, fits in 10 bits before zero-extension to a halfword
   assign sum_a = {2'b0, a[0]} + {2'b0, a[1]} + {2'b0, a[2]} + {2'b0, a[3]};
   assign sum_b = {2'b0, b[0]} + {2'b0, b[1]} + {2'b0, b[2]} + {2'b0, b[3]};

   // select the word result for the decoded operation
   always_comb begin
      res_o = '0;
      case (sel_i)
         SEL_CNTB:  res_o = cnt;
         SEL_AVGB:  res_o = avg;
         SEL_ABSDB: res_o = absd;
         SEL_SUMB:  res_o = {6'd0, sum_b, 6'd0, sum_a};
         default:   res_o = '0;
      endcase
   end

endmodule

module byte_exec_pipe
   import byte_exec_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int ADDR_W  = 7,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       op,
   input  logic [2:0]        format,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [DATA_W-1:0] ra,
   input  logic [DATA_W-1:0] rb,
   input  logic              reg_write,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] rt_wb,
   output logic [ADDR_W-1:0] rt_addr_wb,
   output logic              reg_write_wb,
   output logic              busy
);

   localparam int NUM_LANES = DATA_W / 32;

   // opcodes written MSB-first, matching the decoded-op bit numbering
   localparam logic [10:0] OP_CNTB  = 11'b01010110100;
   localparam logic [10:0] OP_AVGB  = 11'b00011010011;
   localparam logic [10:0] OP_ABSDB = 11'b00001010011;
   localparam logic [10:0] OP_SUMB  = 11'b01001010011;

   if ((DATA_W % 32) != 0 || DATA_W < 32) begin : g_bad_data_w
      $error("byte_exec_pipe: DATA_W must be a positive multiple of 32");
   end
   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("byte_exec_pipe: LATENCY must be in 1..8");
   end

   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic [ADDR_W-1:0] addr;
      logic              we;
   } stage_t;

   sel_e                         sel;
   logic                         op_ok;
   logic [NUM_LANES-1:0][31:0]   lane_res;
   stage_t                       in_d;
   stage_t [LATENCY-1:0]         stg_q, stg_d;

   // decode: only the four format-0 opcodes are real; everything else,
   // including the nop, becomes a bubble
   always_comb begin
      sel   = SEL_CNTB;
      op_ok = 1'b0;
      if (format == 3'd0) begin
         case (op)
            OP_CNTB:  begin sel = SEL_CNTB;  op_ok = 1'b1; end
            OP_AVGB:  begin sel = SEL_AVGB;  op_ok = 1'b1; end
            OP_ABSDB: begin sel = SEL_ABSDB; op_ok = 1'b1; end
            OP_SUMB:  begin sel = SEL_SUMB;  op_ok = 1'b1; end
            default:  begin sel = SEL_CNTB;  op_ok = 1'b0; end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      byte_exec_lane u_lane (
         .sel_i (sel),
         .ra_i  (ra[32*i +: 32]),
         .rb_i  (rb[32*i +: 32]),
         .res_o (lane_res[i])
      );
   end

   // stage-0 entry triple; bubbles carry all zeros
   always_comb begin
      in_d.res  = op_ok ? DATA_W'(lane_res) : '0;
      in_d.addr = op_ok ? rt_addr : '0;
      in_d.we   = op_ok & reg_write;
   end

   // pipeline next state: flush beats stall, stall freezes every stage
   always_comb begin
      stg_d = stg_q;
      if (flush) begin
         stg_d = '0;
      end else if (!stall) begin
         stg_d[0] = in_d;
         for (int s = 1; s < LATENCY; s++) stg_d[s] = stg_q[s-1];
      end
   end

   // pipeline registers; the last stage is the writeback output register
   always_ff @(posedge clk) begin
      if (reset) stg_q <= '0;
      else       stg_q <= stg_d;
   end

   // busy reflects any pending register write, output stage included
   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < LATENCY; s++) busy = busy | stg_q[s].we;
   end

   assign rt_wb        = stg_q[LATENCY-1].res;
   assign rt_addr_wb   = stg_q[LATENCY-1].addr;
   assign reg_write_wb = stg_q[LATENCY-1].we;

endmodule
